// File: rtl/aes_key_expand_if.sv
// rtl/aes_key_expand_if.sv - key-load and round-key read bundle for aes_key_expand
interface aes_key_expand_if;
    logic [127:0] key;
    logic         init;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         ready;

    modport master (output key, init, round, input round_key, ready);
    modport slave  (input key, init, round, output round_key, ready);
endinterface

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - AES-128 key expansion, one round key per clock; AES_KEY_EXPAND_OUT_REG_EN registers round_key
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX[in_byte];
endmodule

module aes_key_expand #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic              clk,
    input  logic              reset,
    aes_key_expand_if.slave   bus
);
    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_GEN    = 1'b1;

    logic [0:0]   state;
    logic [127:0] mem [0:NUM_ROUNDS];
    logic [127:0] prev;
    logic [3:0]   cnt;
    logic [7:0]   rcon;

    logic [31:0]  w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;
    logic [127:0] next_key;
    logic [127:0] rd_key;

    // One expansion step from the previous round key: S-box layer then an XOR chain
    assign w0  = prev[127:96];
    assign w1  = prev[95:64];
    assign w2  = prev[63:32];
    assign w3  = prev[31:0];
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot[8*g +: 8]),
            .out_byte (sub[8*g +: 8])
        );
    end

    assign t        = sub ^ {rcon, 24'h0};
    assign n0       = w0 ^ t;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    assign bus.ready = (state == S_IDLE);

    // Sequencer: load key on init, then write one round key per clock until the last entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            prev  <= '0;
            cnt   <= '0;
            rcon  <= 8'h01;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.init) begin
                        mem[0] <= bus.key;
                        prev   <= bus.key;
                        rcon   <= 8'h01;
                        cnt    <= 4'd1;
                        state  <= S_GEN;
                    end
                end
                default: begin
                    mem[cnt] <= next_key;
                    prev     <= next_key;
                    rcon     <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    cnt      <= cnt + 4'd1;
                    if (cnt == LAST_IDX) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Read mux; indices past the last round read as zero
    always_comb begin
        rd_key = '0;
        if (bus.round <= LAST_IDX) begin
            rd_key = mem[bus.round];
        end
    end

`ifdef AES_KEY_EXPAND_OUT_REG_EN
    logic [127:0] rk_q;

    // Output register decouples the memory mux from the downstream round logic
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rk_q <= '0;
        end else begin
            rk_q <= rd_key;
        end
    end

    assign bus.round_key = rk_q;
`else
    assign bus.round_key = rd_key;
`endif
endmodule

// File: tb/tb_aes_key_expand.sv
// tb/tb_aes_key_expand.sv - randomized self-checking bench for aes_key_expand against a FIPS-197 word model
module tb_aes_key_expand;
    typedef logic [0:10][127:0] ks_t;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    aes_key_expand_if bus ();

    aes_key_expand dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] tb_sbox [0:255];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box derived from GF(2^8) inverse plus affine map
    task automatic build_sbox;
        logic [7:0] inv, b;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            if (v != 0) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(v));
            end
            b = inv;
            tb_sbox[v] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end
    endtask

    function automatic ks_t expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc;
        ks_t ks;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tb_sbox[tmp[23:16]], tb_sbox[tmp[15:8]], tb_sbox[tmp[7:0]], tb_sbox[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    // Timeline model: which entries hold which key after each edge
    logic [127:0] m_mem [0:10];
    ks_t          m_ks;
    int           m_step = 0;
    logic [127:0] m_rk = '0;

    function automatic logic [127:0] m_lookup(input logic [3:0] r);
        return (r <= 4'd10) ? m_mem[r] : 128'h0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 11; i++) m_mem[i] = '0;
            m_step = 0;
            m_rk = '0;
        end else begin
            m_rk = m_lookup(bus.round);
            if (m_step == 0) begin
                if (bus.init) begin
                    m_ks = expand(bus.key);
                    m_mem[0] = bus.key;
                    m_step = 1;
                end
            end else begin
                m_mem[m_step] = m_ks[m_step];
                m_step = (m_step == 10) ? 0 : m_step + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [127:0] exp_rk;
        if (chk_en) begin
`ifdef AES_KEY_EXPAND_OUT_REG_EN
            exp_rk = m_rk;
`else
            exp_rk = m_lookup(bus.round);
`endif
            checks++;
            if (bus.ready !== (m_step == 0)) begin
                errors++;
                $display("FAIL ready_cycle t=%0t got %b want %b", $time, bus.ready, (m_step == 0));
            end
            checks++;
            if (bus.round_key !== exp_rk) begin
                errors++;
                $display("FAIL round_key_cycle t=%0t round=%0d got %h want %h", $time, bus.round, bus.round_key, exp_rk);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic check128(input string nm, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic read_check(input logic [3:0] r, input logic [127:0] want, input string nm);
        bus.round = r;
        @(posedge clk);
        @(negedge clk);
        check128(nm, bus.round_key, want);
        @(posedge clk);
        #2;
    endtask

    // Pulses init and counts cycles until ready returns (accept cycle included); ends on the first ready negedge
    task automatic start_and_wait(input logic [127:0] k, input bit inject, input string nm);
        int lowc;
        bus.key = k;
        bus.init = 1'b1;
        tick();
        bus.init = 1'b0;
        lowc = 1;
        forever begin
            @(negedge clk);
            if (bus.ready || lowc > 40) break;
            lowc++;
            @(posedge clk);
            #2;
            bus.round = 4'($urandom_range(0, 15));
            if (inject && lowc == 5) begin
                bus.key = '1;
                bus.init = 1'b1;
            end else begin
                bus.init = 1'b0;
            end
        end
        bus.init = 1'b0;
        check_int(nm, lowc, 11);
    endtask

    initial begin
        ks_t ks;
        logic [127:0] rk;
        bus.key = '0;
        bus.init = 1'b0;
        bus.round = '0;
        build_sbox();

        check_int("sbox_00", int'(tb_sbox[8'h00]), 'h63);
        check_int("sbox_53", int'(tb_sbox[8'h53]), 'hed);
        ks = expand(FIPS_KEY);
        check128("model_fips_r1", ks[1], FIPS_R1);
        check128("model_fips_r10", ks[10], FIPS_R10);
        ks = expand(SEQ_KEY);
        check128("model_seq_r10", ks[10], SEQ_R10);

        tick();
        tick();
        chk_en = 1'b1;
        reset = 1'b0;
        tick();

        // Load something, then reset mid-cycle and sweep every index
        start_and_wait(128'($urandom) << 64 | 128'($urandom), 1'b0, "pre_reset_len");
        @(posedge clk);
        #4;
        reset = 1'b1;
        #2;
        for (int r = 0; r < 16; r++) begin
            bus.round = 4'(r);
            @(posedge clk);
            @(negedge clk);
            check128("reset_round_key", bus.round_key, 128'h0);
        end
        check_int("reset_ready", int'(bus.ready), 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        tick();

        // FIPS-197 vector and out-of-range reads
        start_and_wait(FIPS_KEY, 1'b0, "fips_ready_low");
        @(posedge clk);
        #2;
        read_check(4'd0, FIPS_KEY, "fips_r0");
        read_check(4'd1, FIPS_R1, "fips_r1");
        read_check(4'd10, FIPS_R10, "fips_r10");
        read_check(4'd11, 128'h0, "oor_11");
        read_check(4'd15, 128'h0, "oor_15");

        // init during GEN is ignored
        start_and_wait(FIPS_KEY, 1'b1, "ignore_init_len");
        @(posedge clk);
        #2;
        read_check(4'd0, FIPS_KEY, "ignore_r0");
        read_check(4'd10, FIPS_R10, "ignore_r10");

        // Reset at GEN cycle 4, then a fresh expansion
        bus.key = {$urandom, $urandom, $urandom, $urandom};
        bus.init = 1'b1;
        tick();
        bus.init = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        start_and_wait(SEQ_KEY, 1'b0, "seq_ready_low");
        @(posedge clk);
        #2;
        read_check(4'd10, SEQ_R10, "seq_r10");

        // Back-to-back: init presented in the first ready cycle
        bus.round = 4'd0;
        start_and_wait(FIPS_KEY, 1'b0, "b2b_first_len");
        bus.key = SEQ_KEY;
        bus.init = 1'b1;
        @(posedge clk);
        #2;
        bus.init = 1'b0;
        @(negedge clk);
        check_int("b2b_accepted", int'(bus.ready), 0);
        @(posedge clk);
        #2;
        read_check(4'd0, SEQ_KEY, "b2b_r0");
        begin
            int cyc = 0;
            while (!bus.ready && cyc < 40) begin
                tick();
                cyc++;
            end
            check_int("b2b_done", int'(bus.ready), 1);
        end

        // Random keys, random stray init pulses, random reads
        for (int n = 0; n < 6; n++) begin
            logic [127:0] k;
            logic [3:0] r;
            k = {$urandom, $urandom, $urandom, $urandom};
            ks = expand(k);
            start_and_wait(k, 1'($urandom_range(0, 1)), "rand_len");
            @(posedge clk);
            #2;
            for (int j = 0; j < 3; j++) begin
                r = 4'($urandom_range(0, 15));
                rk = (r <= 4'd10) ? ks[r] : 128'h0;
                read_check(r, rk, "rand_read");
            end
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
